// File: rtl/pipe_reg_if_id_elastic.sv
// Elastic IF/ID stage: DEPTH-entry circular FIFO between fetch and decode with valid/ready on both sides.
// Optional branch-prediction sideband per entry is enabled by defining IFID_BPRED_EN.
module pipe_reg_if_id_elastic #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] NOP_INSN = XLEN'(32'h00000013)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            instr_in,
  input  logic [XLEN-1:0]            pc_in,
`ifdef IFID_BPRED_EN
  input  logic                       pred_taken_in,
  input  logic [XLEN-1:0]            pred_target_in,
  output logic                       pred_taken_out,
  output logic [XLEN-1:0]            pred_target_out,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            instr_out,
  output logic [XLEN-1:0]            pc_out,
  output logic                       misalign_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic            mis_mem   [DEPTH];
`ifdef IFID_BPRED_EN
  logic            taken_mem  [DEPTH];
  logic [XLEN-1:0] target_mem [DEPTH];
`endif

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshake: a transfer happens on an edge where valid & ready are both high and flush is low.
  // in_ready depends only on the registered count, so no combinational path from out_ready to in_ready.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: it is only observable through out_valid, which reset clears.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr] <= instr_in;
      pc_mem[wr_ptr]    <= pc_in;
      mis_mem[wr_ptr]   <= |pc_in[1:0];
`ifdef IFID_BPRED_EN
      taken_mem[wr_ptr]  <= pred_taken_in;
      target_mem[wr_ptr] <= pred_target_in;
`endif
    end
  end

  assign instr_out    = out_valid ? instr_mem[rd_ptr] : NOP_INSN;
  assign pc_out       = out_valid ? pc_mem[rd_ptr]    : '0;
  assign misalign_out = out_valid ? mis_mem[rd_ptr]   : 1'b0;
`ifdef IFID_BPRED_EN
  assign pred_taken_out  = out_valid ? taken_mem[rd_ptr]  : 1'b0;
  assign pred_target_out = out_valid ? target_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_pipe_reg_if_id_elastic.sv
// Directed bench for pipe_reg_if_id_elastic: a DEPTH=2 instance for the main sequence and a
// DEPTH=4 instance for wrap-around and asynchronous mid-stream reset.
module tb_pipe_reg_if_id_elastic;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // DEPTH=2 instance signals
  logic        a_reset_n, a_flush, a_in_valid, a_out_ready;
  logic [31:0] a_instr_in, a_pc_in;
  logic        a_in_ready, a_out_valid, a_misalign;
  logic [31:0] a_instr_out, a_pc_out;
  logic [1:0]  a_count;

  // DEPTH=4 instance signals
  logic        b_reset_n, b_flush, b_in_valid, b_out_ready;
  logic [31:0] b_instr_in, b_pc_in;
  logic        b_in_ready, b_out_valid, b_misalign;
  logic [31:0] b_instr_out, b_pc_out;
  logic [2:0]  b_count;

  pipe_reg_if_id_elastic #(.XLEN(32), .DEPTH(2)) u_d2 (
    .clock(clock), .reset_n(a_reset_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .instr_in(a_instr_in), .pc_in(a_pc_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .instr_out(a_instr_out),
    .pc_out(a_pc_out), .misalign_out(a_misalign), .count(a_count)
  );

  pipe_reg_if_id_elastic #(.XLEN(32), .DEPTH(4)) u_d4 (
    .clock(clock), .reset_n(b_reset_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .instr_in(b_instr_in), .pc_in(b_pc_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .instr_out(b_instr_out),
    .pc_out(b_pc_out), .misalign_out(b_misalign), .count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic rdy);
    a_in_valid  = v;
    a_instr_in  = instr;
    a_pc_in     = pc;
    a_out_ready = rdy;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic rdy);
    b_in_valid  = v;
    b_instr_in  = instr;
    b_pc_in     = pc;
    b_out_ready = rdy;
  endtask

  task automatic head_a(input string tag, input logic v, input logic [31:0] instr,
                        input logic [31:0] pc, input logic [1:0] cnt);
    chk({tag, ".out_valid"}, 32'(a_out_valid), 32'(v));
    chk({tag, ".instr_out"}, a_instr_out, instr);
    chk({tag, ".pc_out"},    a_pc_out, pc);
    chk({tag, ".count"},     32'(a_count), 32'(cnt));
  endtask

  initial begin
    a_reset_n = 1'b0; a_flush = 1'b0; drive_a(1'b0, '0, '0, 1'b0);
    b_reset_n = 1'b0; b_flush = 1'b0; drive_b(1'b0, '0, '0, 1'b0);
    step();
    step();

    // 1: reset state
    head_a("rst", 1'b0, NOP, 32'h0, 2'd0);
    chk("rst.misalign", 32'(a_misalign), 32'd0);
    a_reset_n = 1'b1; b_reset_n = 1'b1;
    step();
    chk("rst.in_ready", 32'(a_in_ready), 32'd1);
    head_a("rst_rel", 1'b0, NOP, 32'h0, 2'd0);

    // 2: streaming with out_ready=1, one-cycle latency
    drive_a(1'b1, 32'h00000001, 32'h0, 1'b1);
    step();
    head_a("s2.w1", 1'b1, 32'h00000001, 32'h0, 2'd1);
    chk("s2.in_ready1", 32'(a_in_ready), 32'd1);
    drive_a(1'b1, 32'h00000002, 32'h4, 1'b1);
    step();
    head_a("s2.w2", 1'b1, 32'h00000002, 32'h4, 2'd1);
    chk("s2.in_ready2", 32'(a_in_ready), 32'd1);
    drive_a(1'b0, '0, '0, 1'b1);
    step();
    head_a("s2.drain", 1'b0, NOP, 32'h0, 2'd0);

    // 3: back-pressure, full, held upstream word, in-order drain
    drive_a(1'b1, 32'hAAAAAAAA, 32'h8, 1'b0);
    step();
    head_a("s3.a", 1'b1, 32'hAAAAAAAA, 32'h8, 2'd1);
    drive_a(1'b1, 32'hBBBBBBBB, 32'hC, 1'b0);
    step();
    head_a("s3.full", 1'b1, 32'hAAAAAAAA, 32'h8, 2'd2);
    chk("s3.in_ready_full", 32'(a_in_ready), 32'd0);
    drive_a(1'b1, 32'hCCCCCCCC, 32'h10, 1'b0);
    step();
    head_a("s3.stall_hold", 1'b1, 32'hAAAAAAAA, 32'h8, 2'd2);
    drive_a(1'b1, 32'hCCCCCCCC, 32'h10, 1'b1);
    chk("s3.full_rdy_in_ready", 32'(a_in_ready), 32'd0);
    step();
    head_a("s3.b", 1'b1, 32'hBBBBBBBB, 32'hC, 2'd1);
    chk("s3.in_ready_back", 32'(a_in_ready), 32'd1);
    step();
    head_a("s3.c", 1'b1, 32'hCCCCCCCC, 32'h10, 2'd1);
    drive_a(1'b0, '0, '0, 1'b1);
    step();
    head_a("s3.empty", 1'b0, NOP, 32'h0, 2'd0);

    // empty with out_ready=1: no underflow
    step();
    head_a("underflow", 1'b0, NOP, 32'h0, 2'd0);

    // 4: flush beats push and pop
    drive_a(1'b1, 32'h00000011, 32'h20, 1'b0);
    step();
    drive_a(1'b1, 32'h00000022, 32'h24, 1'b0);
    step();
    head_a("s4.pre", 1'b1, 32'h00000011, 32'h20, 2'd2);
    a_flush = 1'b1;
    drive_a(1'b1, 32'hDDDDDDDD, 32'h28, 1'b1);
    chk("s4.flush_in_ready", 32'(a_in_ready), 32'd0);
    step();
    head_a("s4.flushed", 1'b0, NOP, 32'h0, 2'd0);
    a_flush = 1'b0;
    drive_a(1'b0, '0, '0, 1'b1);
    step();
    head_a("s4.no_dddd", 1'b0, NOP, 32'h0, 2'd0);

    // flush with one entry and a valid input: next word after flush lands at a clean head
    drive_a(1'b1, 32'h00000033, 32'h30, 1'b0);
    step();
    a_flush = 1'b1;
    drive_a(1'b1, 32'h00000044, 32'h34, 1'b1);
    step();
    head_a("s4b.flushed", 1'b0, NOP, 32'h0, 2'd0);
    a_flush = 1'b0;
    drive_a(1'b1, 32'h00000045, 32'h38, 1'b0);
    step();
    head_a("s4b.after", 1'b1, 32'h00000045, 32'h38, 2'd1);
    drive_a(1'b0, '0, '0, 1'b1);
    step();

    // 5: misalign flag
    drive_a(1'b1, 32'h00000055, 32'h6, 1'b0);
    step();
    head_a("s5.mis", 1'b1, 32'h00000055, 32'h6, 2'd1);
    chk("s5.misalign1", 32'(a_misalign), 32'd1);
    drive_a(1'b1, 32'h00000066, 32'h8, 1'b0);
    step();
    chk("s5.misalign_hold", 32'(a_misalign), 32'd1);
    drive_a(1'b0, '0, '0, 1'b1);
    step();
    head_a("s5.aligned", 1'b1, 32'h00000066, 32'h8, 2'd1);
    chk("s5.misalign0", 32'(a_misalign), 32'd0);
    step();
    chk("s5.misalign_empty", 32'(a_misalign), 32'd0);

    // 6: DEPTH=4 fill, drain, wrap, async reset
    for (int i = 0; i < 6; i++) begin
      drive_b(1'b1, 32'h100 + 32'(i), 32'h40 + 32'(4 * i), 1'b0);
      step();
      chk($sformatf("s6.fill_count%0d", i), 32'(b_count), (i < 4) ? 32'(i + 1) : 32'd4);
    end
    chk("s6.full_in_ready", 32'(b_in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b0, '0, '0, 1'b1);
      chk($sformatf("s6.pop_instr%0d", i), b_instr_out, 32'h100 + 32'(i));
      chk($sformatf("s6.pop_pc%0d", i), b_pc_out, 32'h40 + 32'(4 * i));
      step();
    end
    chk("s6.drained", 32'(b_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, 32'h200 + 32'(i), 32'h80 + 32'(4 * i), 1'b0);
      step();
    end
    chk("s6.refill", 32'(b_count), 32'd4);
    for (int i = 0; i < 2; i++) begin
      drive_b(1'b0, '0, '0, 1'b1);
      chk($sformatf("s6.pop2_instr%0d", i), b_instr_out, 32'h200 + 32'(i));
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive_b(1'b1, 32'h300 + 32'(i), 32'hC0 + 32'(4 * i), 1'b0);
      step();
    end
    chk("s6.wrap_count", 32'(b_count), 32'd4);
    for (int i = 0; i < 2; i++) begin
      drive_b(1'b0, '0, '0, 1'b1);
      chk($sformatf("s6.wrap_instr%0d", i), b_instr_out, 32'h202 + 32'(i));
      step();
    end
    chk("s6.wrap_next", b_instr_out, 32'h300);
    drive_b(1'b0, '0, '0, 1'b0);
    b_reset_n = 1'b0;
    #1;
    chk("s6.arst_valid", 32'(b_out_valid), 32'd0);
    chk("s6.arst_count", 32'(b_count), 32'd0);
    chk("s6.arst_instr", b_instr_out, NOP);
    chk("s6.arst_in_ready", 32'(b_in_ready), 32'd1);
    step();
    b_reset_n = 1'b1;
    drive_b(1'b1, 32'h400, 32'h100, 1'b0);
    step();
    chk("s6.post_rst_instr", b_instr_out, 32'h400);
    chk("s6.post_rst_count", 32'(b_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
